// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider, signed or unsigned, optional early-out.
// The result is {remainder, quotient}. Signs are fixed up in a single cycle after the magnitude loop.
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abandon,
  input  logic               signdiv,
  input  logic [WIDTH-1:0]   opr1,
  input  logic [WIDTH-1:0]   opr2,
  output logic               busy,
  output logic               ready,
  output logic               dbz,
  output logic [2*WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH:0]   pq_q, pq_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               s1_q, s1_d, s2_q, s2_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag1, mag2, quo, rem;
  logic [CW-1:0]      lz, n_early;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH:0]   step;

  assign mag1 = (signdiv && opr1[WIDTH-1]) ? -opr1 : opr1;
  assign mag2 = (signdiv && opr2[WIDTH-1]) ? -opr2 : opr2;

  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (mag1[i]) lz = CW'(WIDTH - 1 - i);
  end
  assign n_early = (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;

  // The shifted partial remainder is pq_q[2W:W-1]. Its top bit is always 0, so the sign bit of diff is the borrow.
  assign diff = pq_q[2*WIDTH:WIDTH-1] - {2'b00, div_q};
  assign step = diff[WIDTH+1] ? {pq_q[2*WIDTH-1:0], 1'b0}
                              : {diff[WIDTH:0], pq_q[WIDTH-2:0], 1'b1};

  assign quo = pq_q[WIDTH-1:0];
  assign rem = pq_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    pq_d    = pq_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        s1_d  = signdiv & opr1[WIDTH-1];
        s2_d  = signdiv & opr2[WIDTH-1];
        div_d = mag2;
        if (opr2 == '0) begin
          dbz_d   = 1'b1;
          pq_d    = '0;
          state_d = DONE;
        end else begin
          if (EARLY_OUT != 0) begin
            pq_d  = {(WIDTH+1)'(0), mag1 << lz};
            cnt_d = n_early;
          end else begin
            pq_d  = {(WIDTH+1)'(0), mag1};
            cnt_d = CW'(WIDTH);
          end
          state_d = CALC;
        end
      end
      CALC: begin
        pq_d  = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        pq_d    = {1'b0, (s1_q ? -rem : rem), ((s1_q ^ s2_q) ? -quo : quo)};
        state_d = DONE;
      end
      DONE: if (!start) begin
        pq_d    = '0;
        div_d   = '0;
        cnt_d   = '0;
        s1_d    = 1'b0;
        s2_d    = 1'b0;
        dbz_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abandon) begin
      pq_d    = '0;
      div_d   = '0;
      cnt_d   = '0;
      s1_d    = 1'b0;
      s2_d    = 1'b0;
      dbz_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pq_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pq_q    <= pq_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy  = (state_q == CALC) || (state_q == FIX);
  assign ready = (state_q == DONE);
  assign dbz   = dbz_q;
  assign res   = ready ? {rem, quo} : '0;
endmodule
